// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: wait-state FSM over a word-addressed RAM
// Optional range fault reporting is enabled by defining DMEM_RANGE_CHECK_EN.
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_error
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    cnt;
    logic [3:0]    cnt_next;
    logic          accept;
    logic          finish;
    logic          fault_in;
    logic          fault_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   merged;
    logic [31:0]   ram [DEPTH];

    // Fetch tag and sub-word address bits do not affect the access.
    logic unused_ok;
    assign unused_ok = ^{mem_instr, mem_addr[31:AW+2], mem_addr[1:0]};

`ifdef DMEM_RANGE_CHECK_EN
    assign fault_in = (mem_addr >> (AW + 2)) != 32'd0;
`else
    assign fault_in = 1'b0;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_valid) begin
                    state_next = S_ACCEPT;
                    cnt_next   = 4'(WAIT_CYCLES);
                    accept     = 1'b1;
                end
            end
            S_ACCEPT: begin
                if (cnt != 4'd0) begin
                    state_next = S_WAIT;
                end else begin
                    state_next = S_RESP;
                    finish     = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = S_RESP;
                    finish     = 1'b1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Store and load share one path: the response carries the word after the write.
    always_comb begin
        merged = ram[idx_q];
        for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) begin
                merged[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
            fault_q   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            mem_ready <= finish;
            mem_rdata <= (finish && !fault_q) ? merged : 32'h0;
            if (accept) begin
                idx_q   <= mem_addr[AW+1:2];
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
                fault_q <= fault_in;
            end
        end
    end

    // No reset on the array; a reset aborts any pending write.
    always_ff @(posedge clk) begin
        if (!rst && finish && !fault_q) begin
            ram[idx_q] <= merged;
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_error <= 1'b0;
        end else begin
            mem_error <= finish && fault_q;
        end
    end
`else
    assign mem_error = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized bench for dmem_responder at WAIT_CYCLES 0 and 3
`timescale 1ns/1ps
module tb_dmem_responder;
    localparam int DEPTH = 1024;
    localparam int W0    = 0;
    localparam int W1    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        mem_valid [2];
    logic        mem_instr [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_wstrb [2];
    logic        mem_ready [2];
    logic [31:0] mem_rdata [2];
    logic        mem_error [2];

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model [2][DEPTH];

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .mem_valid(mem_valid[0]), .mem_instr(mem_instr[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]),
        .mem_ready(mem_ready[0]), .mem_rdata(mem_rdata[0]), .mem_error(mem_error[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W1)) u_dut3 (
        .clk(clk), .rst(rst[1]), .mem_valid(mem_valid[1]), .mem_instr(mem_instr[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]),
        .mem_ready(mem_ready[1]), .mem_rdata(mem_rdata[1]), .mem_error(mem_error[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    function automatic bit out_of_range(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
        return a >= 32'(DEPTH * 4);
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    // Called at a negedge. b2b: valid is still high from the previous response cycle.
    task automatic do_req(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input bit b2b, input bit keep, input string tag);
        logic [31:0] exp_data;
        bit          flt;
        int          idx;
        int          lat;
        if (!b2b) @(negedge clk);
        mem_valid[d] = 1'b1;
        mem_instr[d] = 1'($urandom_range(0, 1));
        mem_addr[d]  = addr;
        mem_wdata[d] = wdata;
        mem_wstrb[d] = wstrb;
        flt = out_of_range(addr);
        idx = int'((addr >> 2) % DEPTH);
        if (flt) begin
            exp_data = 32'h0;
        end else begin
            exp_data = model[d][idx];
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) exp_data[8*b +: 8] = wdata[8*b +: 8];
            model[d][idx] = exp_data;
        end
        lat = 2 + wait_of(d) + (b2b ? 1 : 0);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            if (i < lat) begin
                check({tag, "/ready_lo"}, 32'(mem_ready[d]), 32'd0);
                check({tag, "/rdata_lo"}, mem_rdata[d], 32'h0);
                check({tag, "/error_lo"}, 32'(mem_error[d]), 32'd0);
            end else begin
                check({tag, "/ready"}, 32'(mem_ready[d]), 32'd1);
                check({tag, "/rdata"}, mem_rdata[d], exp_data);
                check({tag, "/error"}, 32'(mem_error[d]), 32'(flt));
            end
        end
        if (!keep) mem_valid[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] old_word;
        bit          chain;
        bit          keep;
        logic [31:0] a;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; mem_valid[d] = 1'b0; mem_instr[d] = 1'b0;
            mem_addr[d] = 32'h0; mem_wdata[d] = 32'h0; mem_wstrb[d] = 4'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset/ready", 32'(mem_ready[d]), 32'd0);
            check("reset/rdata", mem_rdata[d], 32'h0);
            check("reset/error", 32'(mem_error[d]), 32'd0);
            rst[d] = 1'b0;
        end

        // Give every word a known value before any reads.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                do_req(d, 32'(i * 4), $urandom, 4'hF, 1'b0, 1'b0, "init");

        do_req(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, "w0_store");
        do_req(0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, "w0_load");
        do_req(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, "w3_load");

        for (int d = 0; d < 2; d++) begin
            do_req(d, 32'h20, 32'h11223344, 4'hF, 1'b0, 1'b0, "merge_init");
            do_req(d, 32'h20, 32'h00AA0000, 4'b0100, 1'b0, 1'b0, "merge_store");
            check("merge_model", model[d][8], 32'h11AA3344);
            do_req(d, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, "merge_load");
        end

        for (int d = 0; d < 2; d++) begin
            do_req(d, 32'h10, 32'h0, 4'h0, 1'b0, 1'b1, "b2b_1");
            do_req(d, 32'h20, 32'h0, 4'h0, 1'b1, 1'b1, "b2b_2");
            do_req(d, 32'h0,  32'h0, 4'h0, 1'b1, 1'b0, "b2b_3");
        end

        // Reset while the WAIT_CYCLES=3 instance is counting down on a store.
        old_word = model[1][12];
        @(negedge clk);
        mem_valid[1] = 1'b1; mem_addr[1] = 32'h30; mem_wdata[1] = ~old_word; mem_wstrb[1] = 4'hF;
        repeat (2) begin
            @(negedge clk);
            check("rst_mid/ready_lo", 32'(mem_ready[1]), 32'd0);
        end
        rst[1] = 1'b1; mem_valid[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("rst_mid/ready_held", 32'(mem_ready[1]), 32'd0);
            check("rst_mid/rdata_held", mem_rdata[1], 32'h0);
            @(negedge clk);
        end
        do_req(1, 32'h30, 32'h0, 4'h0, 1'b0, 1'b0, "rst_mid_load");
        check("rst_mid/model", model[1][12], old_word);

        for (int d = 0; d < 2; d++) begin
            do_req(d, 32'h1000, 32'h0, 4'h0, 1'b0, 1'b0, "range_load");
            do_req(d, 32'h1000, $urandom, 4'hF, 1'b0, 1'b0, "range_store");
            do_req(d, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, "range_alias");
        end

        for (int d = 0; d < 2; d++) begin
            chain = 1'b0;
            for (int n = 0; n < 300; n++) begin
                a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 - 1));
                keep = (n != 299) && ($urandom_range(0, 1) == 1);
                do_req(d, a, $urandom, ($urandom_range(0, 1) == 1) ? 4'(($urandom)) : 4'h0,
                       chain, keep, "rand");
                chain = keep;
            end
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
